// File: rtl/seq_mult_ctrl.sv
// Sequential multiplier controller: streams 2-bit slices of b (LSB first) to an external
// A_W x 2 partial-product unit and shift-accumulates the results into the full product.
module seq_mult_ctrl #(
  parameter int unsigned A_W  = 4,
  parameter int unsigned B_W  = 4,
  parameter int unsigned PP_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     in_a,
  input  logic [B_W-1:0]     in_b,
  output logic [A_W-1:0]     pp_a,
  output logic [1:0]         pp_b,
  input  logic [PP_W-1:0]    pp_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] product,
  output logic               busy
);

  localparam int unsigned NS   = B_W / 2;
  localparam int unsigned IW   = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned P_W  = A_W + B_W;
  localparam int unsigned SL_W = A_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [B_W-1:0] b_reg;
  logic [P_W-1:0] acc;
  logic [P_W-1:0] pp_term_c;
  logic [P_W-1:0] acc_sum_c;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  idx_inc_c;
  logic           last_slice_c;
  logic           accept_c;
  logic           in_ready_nxt;
  logic           out_valid_nxt;
  logic           busy_nxt;
  logic           pp_y_unused;

  // Only the low A_W+2 bits of the partial product carry information.
  assign pp_y_unused  = ^pp_y;
  assign pp_term_c    = P_W'(pp_y[SL_W-1:0]) << {idx, 1'b0};
  assign acc_sum_c    = acc + pp_term_c;
  assign idx_inc_c    = idx + IW'(1);
  assign last_slice_c = (idx == IW'(NS - 1));
  assign accept_c     = in_valid & in_ready;

  // State register plus the flags decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_c)     state_nxt = S_MUL;
      S_MUL:   if (last_slice_c) state_nxt = S_DONE;
      S_DONE:  if (out_ready)    state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  // Output decode, one cycle ahead so the flags leave the block from flops.
  always_comb begin
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    busy_nxt      = 1'b0;
    case (state_nxt)
      S_IDLE:  in_ready_nxt  = 1'b1;
      S_MUL:   busy_nxt      = 1'b1;
      S_DONE:  begin
        out_valid_nxt = 1'b1;
        busy_nxt      = 1'b1;
      end
      default: in_ready_nxt  = 1'b1;
    endcase
  end

  // Datapath: operand capture, slice sequencing and shift-accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_reg   <= '0;
      acc     <= '0;
      idx     <= '0;
      product <= '0;
      pp_a    <= '0;
      pp_b    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            b_reg <= in_b;
            pp_a  <= in_a;
            pp_b  <= in_b[1:0];
            acc   <= '0;
            idx   <= '0;
          end
        end
        S_MUL: begin
          acc <= acc_sum_c;
          idx <= idx_inc_c;
          if (last_slice_c) begin
            product <= acc_sum_c;
          end else begin
            pp_b <= b_reg[{idx_inc_c, 1'b0} +: 2];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and random bench for seq_mult_ctrl with a behavioural 4x2 partial-product unit
// whose unused upper output bits carry random junk.
module tb_seq_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] pp_a;
  logic [1:0] pp_b;
  logic [7:0] pp_y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;

  logic [1:0] pp_junk;
  logic [5:0] pp_prod;
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_pop = 0;

  always #5 clk = ~clk;

  assign pp_prod = {2'b00, pp_a} * {4'b0000, pp_b};
  assign pp_y    = {pp_junk, pp_prod};

  seq_mult_ctrl #(.A_W(4), .B_W(4), .PP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .pp_a      (pp_a),
    .pp_b      (pp_b),
    .pp_y      (pp_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs set; records the handshakes of the coming rising edge.
  task automatic tick();
    logic [7:0] e;
    if (in_valid && in_ready) exp_q.push_back({4'b0000, in_a} * {4'b0000, in_b});
    if (out_valid && out_ready) begin
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_product", 32'(product), 32'(e));
      end
      n_pop++;
    end
    pp_junk = 2'($urandom);
    @(negedge clk);
  endtask

  task automatic accept(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    chk("accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_a     = 4'($urandom);
    in_b     = 4'($urandom);
  endtask

  // Full operation with slice-order, latency and product checks, then output handshake.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] s0, input logic [1:0] s1, input logic [7:0] p);
    out_ready = 1'b0;
    accept(a, b);
    chk("mul0_pp_a", 32'(pp_a), 32'(a));
    chk("mul0_pp_b", 32'(pp_b), 32'(s0));
    chk("mul0_busy", 32'(busy), 32'd1);
    chk("mul0_out_valid", 32'(out_valid), 32'd0);
    chk("mul0_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("mul1_pp_b", 32'(pp_b), 32'(s1));
    chk("mul1_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("done_out_valid", 32'(out_valid), 32'd1);
    chk("done_product", 32'(product), 32'(p));
    chk("done_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_product_kept", 32'(product), 32'(p));
  endtask

  initial begin
    int sent;
    int cyc;
    int pop_base;
    logic took;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = 4'd0;
    in_b      = 4'd0;
    pp_junk   = 2'd0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pp_a", 32'(pp_a), 32'd0);
    chk("rst_pp_b", 32'(pp_b), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Max operands, slice order/shift, zero multiplicand.
    run_op(4'd15, 4'd15, 2'd3, 2'd3, 8'hE1);
    run_op(4'd9,  4'd6,  2'd2, 2'd1, 8'h36);
    run_op(4'd0,  4'd13, 2'd1, 2'd3, 8'h00);

    // Back-pressure with a competing operand pair.
    accept(4'd7, 4'd11);
    tick();
    tick();
    in_valid = 1'b1;
    in_a     = 4'd3;
    in_b     = 4'd3;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_product", 32'(product), 32'd77);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_sb_len", 32'(exp_q.size()), 32'd0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_product", 32'(product), 32'd9);
    tick();
    out_ready = 1'b0;

    // Reset during the second MUL cycle.
    accept(4'd12, 4'd10);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    chk("midrst_pp_a", 32'(pp_a), 32'd0);
    chk("midrst_pp_b", 32'(pp_b), 32'd0);
    exp_q.delete();
    @(negedge clk);
    chk("midrst_hold_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_out_valid", 32'(out_valid), 32'd0);
    run_op(4'd5, 4'd5, 2'd1, 2'd1, 8'd25);

    // Random stream with input gaps and output back-pressure.
    sent     = 0;
    cyc      = 0;
    pop_base = n_pop;
    in_valid = 1'b0;
    while ((sent < 100 || (n_pop - pop_base) < 100) && cyc < 5000) begin
      if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_a     = 4'($urandom);
        in_b     = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      took      = in_valid && in_ready;
      tick();
      if (took) begin
        sent++;
        in_valid = 1'b0;
      end
      cyc++;
    end
    chk("stream_sent", 32'(sent), 32'd100);
    chk("stream_received", 32'(n_pop - pop_base), 32'd100);
    chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
- Sequential multiplier controller that sits directly upstream of the 4-bit x 2-bit combinational partial-product multiplier.
- Accepts an A_W-bit x B_W-bit unsigned operand pair over a valid/ready handshake.
- Feeds the multiplier one 2-bit slice of b per cycle, LSB slice first.
- Shift-accumulates the returned partial products and presents the full product on a valid/ready output.

Parameters:
- A_W, 4, multiplicand width; must equal the partial-product unit's a width.
- B_W, 4, multiplier width; must be an even number >= 2. NS = B_W/2 slices.
- PP_W, 8, width of the partial-product input returned by the multiplier. Only bits [A_W+1:0] are used; higher bits are ignored.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands.
- in_a  in  A_W  multiplicand, unsigned.
- in_b  in  B_W  multiplier, unsigned.
- pp_a  out  A_W  multiplicand driven to the partial-product multiplier.
- pp_b  out  2  current b slice driven to the partial-product multiplier.
- pp_y  in  PP_W  partial product returned combinationally (same cycle).
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- product  out  A_W+B_W  unsigned product.
- busy  out  1  high while in MUL or DONE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, pp_a=0, pp_b=0, slice index=0, accumulator=0.
- All outputs are registered or decoded from state; pp_a/pp_b come from registers.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register a_reg=in_a, b_reg=in_b; clear accumulator; idx=0; go to MUL.
- MUL:
  - pp_a=a_reg, pp_b=b_reg[2*idx+1:2*idx].
  - Each edge: acc <= acc + (pp_y[A_W+1:0] << 2*idx), computed at A_W+B_W bits (no overflow possible); idx <= idx+1.
  - On the edge where idx==NS-1: product <= final sum, out_valid<=1, go to DONE.
  - MUL lasts exactly NS cycles.
- DONE:
  - out_valid=1; product held stable; in_ready=0.
  - On out_valid&out_ready: out_valid<=0, go to IDLE.
  - out_ready low holds product and out_valid indefinitely.
- Outside MUL, pp_a and pp_b hold their last values; the downstream value of pp_y is then don't-care.
- Latency: out_valid rises NS clock edges after the accepting edge (default 2).
- Throughput: one operation per NS+2 cycles minimum (accept, NS MUL cycles, output handshake, return to IDLE).
- in_valid during MUL/DONE: ignored; in_ready=0, so operands are not consumed. Upstream must hold them.
- in_a/in_b changing after acceptance: no effect, because operands are registered.
- Zero operands: no special-case path; the full NS cycles always run.
- Reset mid-operation (MUL or DONE): immediately abandons the operation and returns to the reset values above. No output handshake occurs for the abandoned operation.
- product is only meaningful while out_valid=1, but it retains its value after the handshake until the next completion.
- pp_y bits above A_W+1 are ignored even if nonzero.

Test Plan:
- Reset then idle: rst_n low for 3 cycles -> in_ready=1, out_valid=0, product=0x00, busy=0; pp_a/pp_b=0 while rst_n asserted.
- Max operands: in_a=15, in_b=15 accepted -> pp_b=3 then 3, out_valid exactly 2 edges after accept, product=0xE1 (225).
- Slice order and shift: in_a=9, in_b=6 -> pp_b sequence 2,1; product=54 (0x36); in_a=0, in_b=13 -> product=0.
- Back-pressure: in_a=7, in_b=11, out_ready=0 for 5 cycles -> product=77 held stable, out_valid=1, in_ready=0. Competing in_valid with in_a=3, in_b=3 is not accepted. After out_ready=1, the next accepted pair 3x3 gives product=9.
- Reset mid-MUL: accept in_a=12, in_b=10, pull rst_n low during the second MUL cycle -> immediate reset values, no out_valid. A following 5x5 yields 25 with normal latency.
- Back-to-back stream: 100 random unsigned pairs with random out_ready and in_valid gaps -> every product equals a*b, order preserved, no drops or duplicates.
